// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the decode/rename dispatch controller: functional-unit
// encoding, FSM states and the one-hot reservation-station select helper.
package dispatch_ctrl_pkg;

  localparam int NUM_FU = 5;

  typedef enum logic [2:0] {
    to_alu = 3'd0,
    to_mul = 3'd1,
    to_div = 3'd2,
    to_mem = 3'd3,
    to_br  = 3'd4
  } funct_unit_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } dispatch_state_t;

  // Encodings at or above NUM_FU map to no station at all.
  function automatic logic [NUM_FU-1:0] fu_onehot(input funct_unit_t unit);
    logic [NUM_FU-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (unit == funct_unit_t'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_latch.sv
// One-entry dispatch latch: remembers which reservation station the held
// packet targets and pushes it there once that station can accept it.
module dispatch_latch
  import dispatch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  funct_unit_t       load_unit,
  input  logic [NUM_FU-1:0] rs_ready,
  output logic              latch_v,
  output funct_unit_t       latch_unit,
  output logic              drain,
  output logic [NUM_FU-1:0] rs_push
);

  logic        latch_v_q, latch_v_d;
  funct_unit_t latch_unit_q, latch_unit_d;
  logic [NUM_FU-1:0] sel_oh;

  assign sel_oh  = fu_onehot(latch_unit_q);
  assign drain   = latch_v_q & (|(sel_oh & rs_ready));
  // A flush squashes the held packet before it can reach a station.
  assign rs_push = (drain && !flush) ? sel_oh : '0;

  always_comb begin
    latch_v_d    = latch_v_q;
    latch_unit_d = latch_unit_q;
    if (flush) begin
      latch_v_d = 1'b0;
    end else if (load) begin
      latch_v_d    = 1'b1;
      latch_unit_d = load_unit;
    end else if (drain) begin
      latch_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_v_q    <= 1'b0;
      latch_unit_q <= to_alu;
    end else begin
      latch_v_q    <= latch_v_d;
      latch_unit_q <= latch_unit_d;
    end
  end

  assign latch_v    = latch_v_q;
  assign latch_unit = latch_unit_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// Decode/rename dispatch sequencer: pops the IQ, gates ROB/RAT writes,
// assigns program order and recovers from flushes.
//   state | meaning
//   RUN   | normal dispatch, one packet per cycle when nothing backpressures
//   HOLD  | post-flush wait while ROB/RAT restore; no dispatch
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int FLUSH_HOLD  = 2,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [63:0]            flush_order,
  input  logic                   iq_empty,
  input  logic                   dec_valid,
  input  logic [2:0]             dec_unit,
  input  logic [4:0]             dec_rd,
  input  logic                   rob_full,
  input  logic [NUM_FU-1:0]      rs_ready,
  output logic                   iq_pop,
  output logic                   rob_alloc_en,
  output logic                   rat_we,
  output logic                   latch_ld,
  output logic [NUM_FU-1:0]      rs_push,
  output logic [63:0]            order,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  dispatch_state_t          state_q, state_d;
  logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [63:0]              order_q, order_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic        latch_v;
  funct_unit_t latch_unit;
  logic        drain;
  logic        want;
  logic        fire;

  dispatch_latch u_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .load       (fire),
    .load_unit  (funct_unit_t'(dec_unit)),
    .rs_ready   (rs_ready),
    .latch_v    (latch_v),
    .latch_unit (latch_unit),
    .drain      (drain),
    .rs_push    (rs_push)
  );

  assign want = (state_q == RUN) & !flush & !iq_empty & dec_valid;
  // rst_n keeps every strobe low while reset is asserted, even mid-cycle.
  assign fire = rst_n & want & !rob_full & (!latch_v | drain);

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    order_d     = order_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      RUN: ;
      HOLD: begin
        if (hold_cnt_q == '0) state_d = RUN;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (flush) begin
      state_d    = HOLD;
      hold_cnt_d = HOLD_W'(FLUSH_HOLD - 1);
      order_d    = flush_order + 64'd1;
    end else if (fire) begin
      order_d = order_q + 64'd1;
    end

    if (want && !fire && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      hold_cnt_q  <= '0;
      order_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      order_q     <= order_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign iq_pop       = fire;
  assign rob_alloc_en = fire;
  assign latch_ld     = fire;
  assign rat_we       = fire & (dec_rd != 5'd0);
  assign order        = order_q;
  assign busy         = latch_v | (state_q == HOLD);
  assign stall_cnt    = stall_cnt_q;

  a_unit_legal: assert property (@(posedge clk) disable iff (!rst_n)
    fire |-> (dec_unit < 3'(NUM_FU)))
    else $error("dispatch_ctrl: illegal dec_unit %0d dispatched", dec_unit);

endmodule
